control_sequencer: RTL and testbench

- Hardwired control unit that drives the DataPath control strobes (PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZLowIn, Zlowout, register select, ALU opcode).
- Sequences fetch (T0–T2) and execute (T3–T6) from the instruction held in IR.
- Replaces the hand-driven strobe schedule currently used to exercise the datapath.
- Sits beside DataPath. It consumes IR and memory-ready, and produces every datapath control input.

---
 rtl/control_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the DataPath.
// Sequences instruction fetch (T0-T2) and execute (T3-T6) from the
// instruction held in IR and drives every datapath control strobe.
// All outputs are decoded from the current state and ir, so they are
// stable for the whole state cycle.
// Optional build macro MEM_WAIT_EN: T1 holds Read/MDRin until mem_rdy=1.
// Without it mem_rdy is ignored and T1 always lasts one cycle.

module control_sequencer #(
  parameter int unsigned NREGS   = 16,
  parameter logic [4:0]  OP_NOP  = 5'b11010,
  parameter logic [4:0]  OP_HALT = 5'b11011,
  parameter logic [4:0]  OP_MUL  = 5'b01111,
  parameter logic [4:0]  OP_DIV  = 5'b10000
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      ir,
  input  logic             mem_rdy,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             ZLowIn,
  output logic             ZHighIn,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             LOin,
  output logic             HIin,
  output logic [4:0]       opcode,
  output logic [NREGS-1:0] reg_in,
  output logic [NREGS-1:0] reg_out,
  output logic             run,
  output logic             illegal_op
);

  typedef enum logic [3:0] {
    S_RST,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6,
    S_HALT
  } state_t;

  state_t state, state_nxt;

  // Instruction fields
  logic [4:0] op;
  logic [3:0] ra, rb, rc;

  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];

  // Instruction class decode
  logic is_nop, is_halt, is_muldiv, is_alu, is_illegal;

  // Classify the opcode; two-result ops take precedence over the ALU ranges
  always_comb begin
    is_nop     = (op == OP_NOP);
    is_halt    = (op == OP_HALT);
    is_muldiv  = (op == OP_MUL) || (op == OP_DIV);
    is_alu     = !is_muldiv &&
                 ((op <= 5'b01110) || ((op >= 5'b10001) && (op <= 5'b11001)));
    is_illegal = !(is_nop || is_halt || is_muldiv || is_alu);
  end

  // Memory-ready gating of the fetch read cycle
  logic t1_done;
`ifdef MEM_WAIT_EN
  assign t1_done = mem_rdy;
`else
  assign t1_done = 1'b1;
  logic unused_mem_rdy;
  assign unused_mem_rdy = mem_rdy;
`endif

  logic unused_ir;
  assign unused_ir = ^ir[14:0];

  // State register, asynchronously forced to S_RST while clear is low
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode from state and ir
  always_comb begin
    state_nxt  = state;
    PCout      = 1'b0;
    PCin       = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    ZLowIn     = 1'b0;
    ZHighIn    = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    LOin       = 1'b0;
    HIin       = 1'b0;
    opcode     = '0;
    reg_in     = '0;
    reg_out    = '0;
    run        = 1'b0;
    illegal_op = 1'b0;

    unique case (state)
      S_RST: begin
        state_nxt = T0;
      end

      T0: begin
        run       = 1'b1;
        PCout     = 1'b1;
        MARin     = 1'b1;
        IncPC     = 1'b1;
        state_nxt = T1;
      end

      T1: begin
        run   = 1'b1;
        Read  = 1'b1;
        MDRin = 1'b1;
        if (t1_done) begin
          state_nxt = T2;
        end
      end

      T2: begin
        run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
        if (is_halt) begin
          state_nxt = S_HALT;
        end else if (is_alu || is_muldiv) begin
          state_nxt = T3;
        end else begin
          // NOP and undefined opcodes both return to fetch
          illegal_op = is_illegal;
          state_nxt  = T0;
        end
      end

      T3: begin
        run = 1'b1;
        Yin = 1'b1;
        for (int unsigned i = 0; i < NREGS; i++) begin
          reg_out[i] = (32'(rb) == i);
        end
        state_nxt = T4;
      end

      T4: begin
        run     = 1'b1;
        opcode  = op;
        ZLowIn  = 1'b1;
        ZHighIn = is_muldiv;
        for (int unsigned i = 0; i < NREGS; i++) begin
          reg_out[i] = (32'(rc) == i);
        end
        state_nxt = T5;
      end

      T5: begin
        run     = 1'b1;
        Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin      = 1'b1;
          state_nxt = T6;
        end else begin
          for (int unsigned i = 0; i < NREGS; i++) begin
            reg_in[i] = (32'(ra) == i);
          end
          state_nxt = T0;
        end
      end

      T6: begin
        run       = 1'b1;
        Zhighout  = 1'b1;
        HIin      = 1'b1;
        state_nxt = T0;
      end

      S_HALT: begin
        state_nxt = S_HALT;
      end

      default: begin
        state_nxt = S_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: instruction-level model (step counter
// per instruction length) compared every cycle, plus literal checks.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic [31:0] ir;
  logic        mem_rdy;
  logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin;
  logic        ZLowIn, ZHighIn, Zlowout, Zhighout, LOin, HIin;
  logic [4:0]  opcode;
  logic [15:0] reg_in, reg_out;
  logic        run, illegal_op;

  int checks = 0;
  int errors = 0;

  control_sequencer #(.NREGS(16)) dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_rdy(mem_rdy),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .LOin(LOin), .HIin(HIin), .opcode(opcode), .reg_in(reg_in),
    .reg_out(reg_out), .run(run), .illegal_op(illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [53:0] dut_vec;
  assign dut_vec = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin,
                    ZLowIn, ZHighIn, Zlowout, Zhighout, LOin, HIin, opcode,
                    reg_in, reg_out, run, illegal_op};

  // ---------------- model ----------------
  bit m_rst  = 1'b1;
  bit m_halt = 1'b0;
  int m_step = 0;

  function automatic int instr_len(input logic [31:0] i);
    logic [4:0] o;
    o = i[31:27];
    if (o == 5'd26 || o >= 5'd28) return 3;
    if (o == 5'd15 || o == 5'd16) return 7;
    return 6;
  endfunction

  function automatic logic [53:0] model_out(input logic [31:0] i, input int step,
                                            input bit halted, input bit rst);
    logic pco, inc, mar, rd, mdi, mdo, iri, y, zli, zhi, zlo, zho, lo, hi, rn, ill;
    logic [4:0]  o, opc;
    logic [15:0] rin, rout;
    bit muldiv;
    o = i[31:27];
    muldiv = (o == 5'd15) || (o == 5'd16);
    {pco, inc, mar, rd, mdi, mdo, iri, y, zli, zhi, zlo, zho, lo, hi, rn, ill} = '0;
    opc = '0; rin = '0; rout = '0;
    if (!rst && !halted) begin
      rn = 1'b1;
      case (step)
        0: begin pco = 1; mar = 1; inc = 1; end
        1: begin rd = 1; mdi = 1; end
        2: begin mdo = 1; iri = 1; ill = (o >= 5'd28); end
        3: begin y = 1; rout = 16'(1) << i[22:19]; end
        4: begin zli = 1; zhi = muldiv; opc = o; rout = 16'(1) << i[18:15]; end
        5: begin zlo = 1; if (muldiv) lo = 1; else rin = 16'(1) << i[26:23]; end
        6: begin zho = 1; hi = 1; end
        default: ;
      endcase
    end
    return {pco, 1'b0, inc, mar, rd, mdi, mdo, iri, y, zli, zhi, zlo, zho, lo, hi,
            opc, rin, rout, rn, ill};
  endfunction

  // Model advances one instruction step per cycle
  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      m_rst = 1'b1; m_halt = 1'b0; m_step = 0;
    end else if (m_rst) begin
      m_rst = 1'b0; m_step = 0;
    end else if (!m_halt) begin
`ifdef MEM_WAIT_EN
      if (m_step == 1 && !mem_rdy) m_step = 1;
      else
`endif
      if (m_step == 2 && ir[31:27] == 5'd27) m_halt = 1'b1;
      else m_step = (m_step + 1) % instr_len(ir);
    end
  end

  bit cmp_en = 1'b0;

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (cmp_en) begin
      logic [53:0] e;
      e = model_out(ir, m_step, m_halt, m_rst);
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL model_cmp t=%0t step=%0d actual=%h required=%h",
                 $time, m_step, dut_vec, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Wait (bounded) until the model is in the given step; lands at posedge+1
  task automatic wait_step(input int s);
    int n;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!(m_step == s && !m_rst && !m_halt) && n < 60);
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL wait_step%0d timeout", s);
    end
  endtask

  // From a T0 cycle, count cycles until the next PCout, noting Yin
  task automatic period(input string name, input int exp, input bit no_yin);
    int n;
    bit ysn;
    n = 0; ysn = 0;
    do begin
      @(posedge clock); #1;
      n++;
      if (Yin) ysn = 1;
    end while (!PCout && n < 30);
    chk(name, n, exp);
    if (no_yin) chk({name, "_yin"}, 32'(ysn), 0);
  endtask

  initial begin
    int rc, nz;
    clear = 1'b1; ir = 32'h2A1B8000; mem_rdy = 1'b1;
    #1 clear = 1'b0;
    cmp_en = 1'b1;
    #2;
    chk("rst_run", 32'(run), 0);
    chk("rst_regout", 32'(reg_out), 0);
    chk("rst_pcout", 32'(PCout), 0);
    @(posedge clock); #1;
    @(posedge clock); #1 clear = 1'b1;
    @(posedge clock); #1;
    chk("t0_strobes", {29'd0, PCout, MARin, IncPC}, 3'b111);
    chk("t0_run", 32'(run), 1);

    // AND R4,R3,R7
    wait_step(3);
    chk("and_t3_regout", 32'(reg_out), 32'h0008);
    chk("and_t3_yin", 32'(Yin), 1);
    wait_step(4);
    chk("and_t4_regout", 32'(reg_out), 32'h0080);
    chk("and_t4_opcode", 32'(opcode), 32'h5);
    chk("and_t4_zlowin", 32'(ZLowIn), 1);
    wait_step(5);
    chk("and_t5_zlowout", 32'(Zlowout), 1);
    chk("and_t5_regin", 32'(reg_in), 32'h0010);
    wait_step(0);
    period("and_period", 6, 0);

    // Reset during T4
    wait_step(4);
    clear = 1'b0; #1;
    chk("midrst_all", 32'(|dut_vec), 0);
    chk("midrst_run", 32'(run), 0);
    @(posedge clock); #1 clear = 1'b1;
    @(posedge clock); #1;
    chk("midrst_t0", {29'd0, PCout, MARin, IncPC}, 3'b111);

    // MUL
    ir = 32'h781B8000;
    wait_step(4);
    chk("mul_t4", {30'd0, ZLowIn, ZHighIn}, 2'b11);
    wait_step(5);
    chk("mul_t5", {30'd0, Zlowout, LOin}, 2'b11);
    chk("mul_t5_regin", 32'(reg_in), 0);
    wait_step(6);
    chk("mul_t6", {30'd0, Zhighout, HIin}, 2'b11);
    chk("mul_t6_regin", 32'(reg_in), 0);
    wait_step(0);
    period("mul_period", 7, 0);

    // NOP
    ir = 32'hD0000000;
    wait_step(0);
    period("nop_period", 3, 1);

    // Memory wait during T1
    ir = 32'h2A1B8000;
    wait_step(0);
    mem_rdy = 1'b0;
    rc = 0; nz = 0;
    do begin
      @(posedge clock); #1;
      nz++;
      if (Read && MDRin) rc++;
      if (rc == 4) mem_rdy = 1'b1;
    end while (!IRin && nz < 20);
    mem_rdy = 1'b1;
`ifdef MEM_WAIT_EN
    chk("memwait_t1_len", rc, 4);
`else
    chk("memwait_t1_len", rc, 1);
`endif

    // Illegal opcode
    wait_step(0);
    ir = 32'hF8000000;
    wait_step(2);
    chk("illegal_t2", 32'(illegal_op), 1);
    @(posedge clock); #1;
    chk("illegal_then_t0", {30'd0, illegal_op, PCout}, 2'b01);

    // HALT
    ir = 32'hD8000000;
    wait_step(2);
    chk("halt_t2_run", 32'(run), 1);
    @(posedge clock); #1;
    chk("halt_run", 32'(run), 0);
    nz = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      if (|dut_vec) nz++;
    end
    chk("halt_quiet", nz, 0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
